rpc_phy_responder: RTL and testbench

RPC_PHY_RESPONDER -- requirements
Module: rpc_phy_responder

---
 rtl/rpc_ctrl_pkg.sv | 19 +
 rtl/rpc_resp_mem.sv | 31 +++
 rtl/rpc_phy_responder.sv | 120 ++++++++++++
 tb/tb_rpc_phy_responder.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpc_ctrl_pkg.sv
// Shared control types for the RPC PHY responder: command kind, responder FSM states
// and the nibble granularity of the write mask.
package rpc_ctrl_pkg;

  localparam int unsigned NibbleW = 4;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } rpc_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_READ    = 2'd3
  } rpc_state_e;

endpackage

// File: rtl/rpc_resp_mem.sv
// Single-port word store: nibble-masked synchronous write, combinational read.
// A set mask bit preserves the corresponding nibble; no reset, so contents survive rst_ni.
module rpc_resp_mem
  import rpc_ctrl_pkg::*;
#(
  parameter int unsigned Width = 256,
  parameter int unsigned Depth = 256,
  parameter int unsigned MaskW = Width / NibbleW,
  parameter int unsigned IdxW  = $clog2(Depth)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [IdxW-1:0]  i_idx,
  input  logic [Width-1:0] i_wdata,
  input  logic [MaskW-1:0] i_wmask,
  output logic [Width-1:0] o_rdata
);

  logic [Width-1:0] r_mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < int'(MaskW); i++) begin
        if (!i_wmask[i]) r_mem[i_idx][NibbleW*i +: NibbleW] <= i_wdata[NibbleW*i +: NibbleW];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/rpc_phy_responder.sv
// PHY-side DRAM responder: one command at a time, write beats stored as accepted, read beats
// valid ReadLatency wait cycles after accept; read data held under backpressure, one beat/cycle otherwise.
module rpc_phy_responder
  import rpc_ctrl_pkg::*;
#(
  parameter int unsigned DramWordWidth = 256,
  parameter int unsigned DramAddrWidth = 20,
  parameter int unsigned DramLenWidth  = 6,
  parameter int unsigned MaskWidth     = 64,
  parameter int unsigned MemDepth      = 256,
  parameter int unsigned ReadLatency   = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  input  logic                     cmd_is_write_i,
  input  logic [DramLenWidth-1:0]  cmd_len_i,
  input  logic [DramAddrWidth-1:0] cmd_addr_i,
  output logic                     cmd_ready_o,
  input  logic                     phy_w_data_valid_i,
  input  logic [DramWordWidth-1:0] phy_w_data_i,
  input  logic [MaskWidth-1:0]     write_mask_i,
  output logic                     phy_w_data_ready_o,
  input  logic                     phy_r_data_ready_i,
  output logic                     phy_r_data_valid_o,
  output logic [DramWordWidth-1:0] phy_r_data_o,
  output logic                     phy_r_data_last_o
);

  localparam int unsigned IdxW  = $clog2(MemDepth);
  localparam int unsigned WaitW = $clog2(ReadLatency + 1);

  rpc_state_e              r_state;
  rpc_state_e              w_state_nxt;
  logic [IdxW-1:0]         r_addr;
  logic [DramLenWidth-1:0] r_len;
  logic [DramLenWidth-1:0] r_beat;
  logic [WaitW-1:0]        r_wait;

  logic                     w_cmd_acc;
  logic                     w_wr_hs;
  logic                     w_rd_hs;
  logic                     w_last_beat;
  logic                     w_wait_done;
  logic [IdxW-1:0]          w_idx;
  logic [DramWordWidth-1:0] w_mem_rdata;

  assign w_cmd_acc   = cmd_valid_i && cmd_ready_o;
  assign w_wr_hs     = phy_w_data_valid_i && phy_w_data_ready_o;
  assign w_rd_hs     = phy_r_data_valid_o && phy_r_data_ready_i;
  // Beat counts up to len and never past it, so len = all-ones cannot overflow.
  assign w_last_beat = (r_beat == r_len);
  assign w_wait_done = (r_wait == WaitW'(ReadLatency - 1));
  assign w_idx       = r_addr + IdxW'(r_beat);

  always_comb begin
    w_state_nxt        = r_state;
    cmd_ready_o        = 1'b0;
    phy_w_data_ready_o = 1'b0;
    phy_r_data_valid_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          w_state_nxt = (rpc_cmd_e'(cmd_is_write_i) == CMD_WRITE) ? ST_WRITE : ST_RD_WAIT;
        end
      end
      ST_WRITE: begin
        phy_w_data_ready_o = 1'b1;
        if (phy_w_data_valid_i && w_last_beat) w_state_nxt = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (w_wait_done) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        phy_r_data_valid_o = 1'b1;
        if (phy_r_data_ready_i && w_last_beat) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign phy_r_data_last_o = phy_r_data_valid_o && w_last_beat;
  assign phy_r_data_o      = phy_r_data_valid_o ? w_mem_rdata : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_acc) begin
        r_addr <= IdxW'(cmd_addr_i);
        r_len  <= cmd_len_i;
        r_beat <= '0;
        r_wait <= '0;
      end
      if (r_state == ST_RD_WAIT) r_wait <= r_wait + 1'b1;
      if (w_wr_hs || w_rd_hs) r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
    end
  end

  rpc_resp_mem #(
    .Width (DramWordWidth),
    .Depth (MemDepth),
    .MaskW (MaskWidth),
    .IdxW  (IdxW)
  ) u_mem (
    .i_clk   (clk_i),
    .i_we    (w_wr_hs),
    .i_idx   (w_idx),
    .i_wdata (phy_w_data_i),
    .i_wmask (write_mask_i),
    .o_rdata (w_mem_rdata)
  );

endmodule

// File: tb/tb_rpc_phy_responder.sv
// Self-checking bench for rpc_phy_responder against an array model of the word store.
module tb_rpc_phy_responder;

  localparam int W     = 256;
  localparam int AW    = 20;
  localparam int LW    = 6;
  localparam int MW    = 64;
  localparam int DEPTH = 256;
  localparam int RL    = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_is_write_i = 1'b0;
  logic [LW-1:0] cmd_len_i = '0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic          cmd_ready_o;
  logic          phy_w_data_valid_i = 1'b0;
  logic [W-1:0]  phy_w_data_i = '0;
  logic [MW-1:0] write_mask_i = '0;
  logic          phy_w_data_ready_o;
  logic          phy_r_data_ready_i = 1'b0;
  logic          phy_r_data_valid_o;
  logic [W-1:0]  phy_r_data_o;
  logic          phy_r_data_last_o;

  int checks = 0;
  int failures = 0;

  logic [W-1:0]  model [DEPTH];
  logic [W-1:0]  wq_data [$];
  logic [MW-1:0] wq_mask [$];
  logic [W-1:0]  obs [$];

  always #5 clk_i = ~clk_i;

  rpc_phy_responder #(
    .DramWordWidth (W), .DramAddrWidth (AW), .DramLenWidth (LW),
    .MaskWidth (MW), .MemDepth (DEPTH), .ReadLatency (RL)
  ) dut (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .cmd_valid_i (cmd_valid_i), .cmd_is_write_i (cmd_is_write_i),
    .cmd_len_i (cmd_len_i), .cmd_addr_i (cmd_addr_i), .cmd_ready_o (cmd_ready_o),
    .phy_w_data_valid_i (phy_w_data_valid_i), .phy_w_data_i (phy_w_data_i),
    .write_mask_i (write_mask_i), .phy_w_data_ready_o (phy_w_data_ready_o),
    .phy_r_data_ready_i (phy_r_data_ready_i), .phy_r_data_valid_o (phy_r_data_valid_o),
    .phy_r_data_o (phy_r_data_o), .phy_r_data_last_o (phy_r_data_last_o)
  );

  function automatic logic [W-1:0] rnd256();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [W-1:0] masked_merge(logic [W-1:0] old_w, logic [W-1:0] new_w, logic [MW-1:0] m);
    logic [W-1:0] r;
    for (int i = 0; i < MW; i++) r[4*i +: 4] = m[i] ? old_w[4*i +: 4] : new_w[4*i +: 4];
    return r;
  endfunction

  function automatic bit ready_pat(int mode, int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 2) == 0;
    return $urandom_range(0, 2) != 0;
  endfunction

  // Presents a command on the next cycle; the DUT is expected to be idle whenever this is called.
  task automatic send_cmd(input bit is_wr, input int len, input int addr);
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_is_write_i = is_wr;
    cmd_len_i = LW'(len);
    cmd_addr_i = AW'(addr);
    #1;
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL cmd_ready_on_issue: got %b exp 1", cmd_ready_o);
    end
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  // Write burst using wq_data/wq_mask; valid is randomly gapped.
  task automatic do_write(input int addr, input int len);
    int b = 0;
    int cyc = 0;
    send_cmd(1'b1, len, addr);
    while (b <= len && cyc < 600) begin
      @(negedge clk_i);
      phy_w_data_valid_i = ($urandom_range(0, 3) != 0);
      phy_w_data_i = wq_data[b];
      write_mask_i = wq_mask[b];
      #1;
      checks++;
      if (phy_w_data_ready_o !== 1'b1) begin
        failures++;
        $display("FAIL w_ready_in_write: got %b exp 1", phy_w_data_ready_o);
      end
      if (phy_w_data_valid_i) begin
        model[(addr + b) % DEPTH] = masked_merge(model[(addr + b) % DEPTH], wq_data[b], wq_mask[b]);
        b++;
      end
      @(posedge clk_i);
      cyc++;
    end
    #1;
    phy_w_data_valid_i = 1'b0;
    checks++;
    if (b <= len || cmd_ready_o !== 1'b1 || phy_w_data_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL write_end_idle: beats=%0d cmd_ready=%b w_ready=%b exp beats=%0d 1 0", b, cmd_ready_o, phy_w_data_ready_o, len + 1);
    end
    wq_data.delete();
    wq_mask.delete();
  endtask

  task automatic do_read(input int addr, input int len, input int mode);
    int b = 0;
    int k = 0;
    int cyc = 0;
    int lat = 0;
    bit stalled = 0;
    logic [W-1:0] prev = '0;
    obs.delete();
    send_cmd(1'b0, len, addr);
    phy_r_data_ready_i = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_i);
      #1;
      if (phy_r_data_valid_o === 1'b1) break;
      lat++;
      @(posedge clk_i);
    end
    checks++;
    if (lat != RL) begin
      failures++;
      $display("FAIL read_latency: got %0d wait cycles exp %0d", lat, RL);
    end
    phy_r_data_ready_i = ready_pat(mode, 0);
    while (b <= len && cyc < 600) begin
      checks++;
      if (phy_r_data_valid_o !== 1'b1 || phy_r_data_o !== model[(addr + b) % DEPTH] ||
          phy_r_data_last_o !== (b == len)) begin
        failures++;
        $display("FAIL read_beat%0d: valid=%b last=%b data=%h exp 1 %b %h", b, phy_r_data_valid_o,
                 phy_r_data_last_o, phy_r_data_o, (b == len), model[(addr + b) % DEPTH]);
      end
      if (stalled) begin
        checks++;
        if (phy_r_data_o !== prev) begin
          failures++;
          $display("FAIL read_stall_hold: got %h exp %h", phy_r_data_o, prev);
        end
      end
      prev = phy_r_data_o;
      stalled = !phy_r_data_ready_i;
      if (phy_r_data_ready_i) begin
        obs.push_back(phy_r_data_o);
        b++;
      end
      @(posedge clk_i);
      cyc++;
      if (b <= len) begin
        @(negedge clk_i);
        k++;
        phy_r_data_ready_i = ready_pat(mode, k);
        #1;
      end
    end
    #1;
    checks++;
    if (b <= len || phy_r_data_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL read_end_idle: beats=%0d valid=%b cmd_ready=%b exp %0d 0 1", b, phy_r_data_valid_o, cmd_ready_o, len + 1);
    end
    phy_r_data_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (phy_w_data_ready_o !== 1'b0 || phy_r_data_valid_o !== 1'b0 ||
        phy_r_data_last_o !== 1'b0 || phy_r_data_o !== '0) begin
      failures++;
      $display("FAIL reset_outputs: w_rdy=%b r_vld=%b last=%b data=%h exp 0 0 0 0",
               phy_w_data_ready_o, phy_r_data_valid_o, phy_r_data_last_o, phy_r_data_o);
    end
    rst_ni = 1'b1;
    #1;
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready_o);
    end
  endtask

  task automatic test_prefill();
    for (int blk = 0; blk < DEPTH / 64; blk++) begin
      for (int i = 0; i < 64; i++) begin
        wq_data.push_back(rnd256());
        wq_mask.push_back('0);
      end
      do_write(blk * 64, 63);
    end
    do_read(192, 63, 2);
  endtask

  task automatic test_single_beat();
    logic [W-1:0] a5;
    for (int i = 0; i < W / 8; i++) a5[8*i +: 8] = 8'hA5;
    wq_data.push_back(a5);
    wq_mask.push_back('0);
    do_write('h10, 0);
    do_read('h10, 0, 0);
    checks++;
    if (obs.size() != 1 || obs[0] !== a5) begin
      failures++;
      $display("FAIL single_beat_data: beats=%0d exp 1 data=%h", obs.size(), (obs.size() > 0) ? obs[0] : '0);
    end
  endtask

  task automatic test_stalled_burst();
    for (int i = 1; i <= 4; i++) begin
      wq_data.push_back(W'(i));
      wq_mask.push_back('0);
    end
    do_write('h20, 3);
    do_read('h20, 3, 1);
    checks++;
    if (obs.size() != 4 || obs[0] !== W'(1) || obs[1] !== W'(2) || obs[2] !== W'(3) || obs[3] !== W'(4)) begin
      failures++;
      $display("FAIL stalled_burst_order: beats=%0d exp 4 with 1,2,3,4", obs.size());
    end
  endtask

  task automatic test_mask();
    logic [W-1:0] ones;
    logic [W-1:0] expv;
    ones = '1;
    expv = {{(W/2){1'b1}}, {(W/2){1'b0}}};
    wq_data.push_back(ones);
    wq_mask.push_back('0);
    do_write('h05, 0);
    wq_data.push_back('0);
    wq_mask.push_back(64'hFFFF_FFFF_0000_0000);
    do_write('h05, 0);
    do_read('h05, 0, 0);
    checks++;
    if (obs.size() != 1 || obs[0] !== expv) begin
      failures++;
      $display("FAIL mask_merge: got %h exp %h", (obs.size() > 0) ? obs[0] : '0, expv);
    end
  endtask

  task automatic test_wrap();
    wq_data.push_back(W'(7));
    wq_mask.push_back('0);
    wq_data.push_back(W'(8));
    wq_mask.push_back('0);
    do_write(DEPTH - 1, 1);
    do_read(0, 0, 0);
    checks++;
    if (obs.size() != 1 || obs[0] !== W'(8)) begin
      failures++;
      $display("FAIL addr_wrap: got %h exp 8", (obs.size() > 0) ? obs[0] : '0);
    end
    do_read(DEPTH - 1, 1, 2);
  endtask

  task automatic test_idle_write_ignored();
    int a = $urandom_range(0, DEPTH - 1);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk_i);
      phy_w_data_valid_i = 1'b1;
      phy_w_data_i = rnd256();
      write_mask_i = '0;
      cmd_addr_i = AW'(a);
      #1;
      checks++;
      if (phy_w_data_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL idle_w_ready: got %b exp 0", phy_w_data_ready_o);
      end
    end
    @(posedge clk_i);
    #1;
    phy_w_data_valid_i = 1'b0;
    do_read(a, 0, 0);
    do_read(0, 7, 2);
  endtask

  task automatic test_reset_mid_read();
    int a = $urandom_range(0, DEPTH - 1);
    int n = 0;
    send_cmd(1'b0, 5, a);
    phy_r_data_ready_i = 1'b1;
    while (n < 40) begin
      @(negedge clk_i);
      #1;
      if (phy_r_data_valid_o === 1'b1) break;
      n++;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    checks++;
    if (phy_r_data_valid_o !== 1'b1 || phy_r_data_o !== model[(a + 1) % DEPTH]) begin
      failures++;
      $display("FAIL reset_mid_beat2: valid=%b data=%h exp 1 %h", phy_r_data_valid_o, phy_r_data_o, model[(a + 1) % DEPTH]);
    end
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    checks++;
    if (phy_r_data_valid_o !== 1'b0 || phy_r_data_last_o !== 1'b0 || phy_r_data_o !== '0) begin
      failures++;
      $display("FAIL reset_abort: valid=%b last=%b data=%h exp 0 0 0", phy_r_data_valid_o, phy_r_data_last_o, phy_r_data_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    phy_r_data_ready_i = 1'b0;
    #1;
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_abort_cmd_ready: got %b exp 1", cmd_ready_o);
    end
    do_read(a, 5, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int a = $urandom_range(0, DEPTH - 1);
      int l = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= l; i++) begin
          wq_data.push_back(rnd256());
          wq_mask.push_back({$urandom, $urandom});
        end
        do_write(a, l);
        do_read(a, l, int'($urandom_range(0, 2)));
      end else begin
        do_read(a, l, int'($urandom_range(0, 2)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_single_beat();
    test_stalled_burst();
    test_mask();
    test_wrap();
    test_idle_write_ignored();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
